// File: rtl/cw305_axi_initiator.sv
// cw305_axi_initiator: one-outstanding AXI4-Lite master driven by CW305
// host commands, with a bounded wait on the B/R response channels.
module cw305_axi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_insn,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  localparam logic LP_TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] LP_LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_rsp_valid;
  logic                 r_rsp_timeout;
  logic [31:0]          r_rsp_rdata;
  logic                 r_awvalid;
  logic [31:0]          r_awaddr;
  logic                 r_wvalid;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic                 r_bready;
  logic                 r_arvalid;
  logic [31:0]          r_araddr;
  logic [2:0]           r_arprot;
  logic                 r_rready;
  logic [TIMEOUT_W-1:0] r_cnt;

  logic                 w_cmd_ready_nxt;
  logic                 w_rsp_valid_nxt;
  logic                 w_rsp_timeout_nxt;
  logic [31:0]          w_rsp_rdata_nxt;
  logic                 w_awvalid_nxt;
  logic [31:0]          w_awaddr_nxt;
  logic                 w_wvalid_nxt;
  logic [31:0]          w_wdata_nxt;
  logic [3:0]           w_wstrb_nxt;
  logic                 w_bready_nxt;
  logic                 w_arvalid_nxt;
  logic [31:0]          w_araddr_nxt;
  logic [2:0]           w_arprot_nxt;
  logic                 w_rready_nxt;
  logic [TIMEOUT_W-1:0] w_cnt_nxt;

  logic w_acc;
  logic w_aw_left;
  logic w_w_left;
  logic w_ar_hs;
  logic w_b_hs;
  logic w_r_hs;
  logic w_tmo;

  // cmd_ready is only ever high in IDLE, so it also gates acceptance
  assign w_acc     = cmd_valid & r_cmd_ready;
  assign w_aw_left = r_awvalid & ~mem_axi_awready;
  assign w_w_left  = r_wvalid & ~mem_axi_wready;
  assign w_ar_hs   = r_arvalid & mem_axi_arready;
  assign w_b_hs    = r_bready & mem_axi_bvalid;
  assign w_r_hs    = r_rready & mem_axi_rvalid;
  assign w_tmo     = LP_TMO_EN & (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      r_awvalid     <= 1'b0;
      r_awaddr      <= '0;
      r_wvalid      <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_arprot      <= '0;
      r_rready      <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_busy        <= ~w_cmd_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_awaddr      <= w_awaddr_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wstrb       <= w_wstrb_nxt;
      r_bready      <= w_bready_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_araddr      <= w_araddr_nxt;
      r_arprot      <= w_arprot_nxt;
      r_rready      <= w_rready_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_nxt = cmd_write ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        if (!w_aw_left && !w_w_left) begin
          w_state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        if (w_b_hs || w_tmo) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RADDR: begin
        if (w_ar_hs) begin
          w_state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        if (w_r_hs || w_tmo) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_awvalid_nxt   = (w_acc & cmd_write) | w_aw_left;
    w_wvalid_nxt    = (w_acc & cmd_write) | w_w_left;
    w_arvalid_nxt   = (w_acc & ~cmd_write) | (r_arvalid & ~mem_axi_arready);
    w_bready_nxt    = (w_state_nxt == S_WRESP);
    w_rready_nxt    = (w_state_nxt == S_RDATA);

    w_rsp_valid_nxt = (r_state == S_WRESP || r_state == S_RDATA) &&
                      (w_state_nxt == S_IDLE);
    // a response landing on the limit cycle still counts as a response
    w_rsp_timeout_nxt = w_rsp_valid_nxt & ~(w_b_hs | w_r_hs);
    w_rsp_rdata_nxt   = r_rsp_rdata;
    if (w_r_hs) begin
      w_rsp_rdata_nxt = mem_axi_rdata;
    end else if (w_rsp_timeout_nxt) begin
      w_rsp_rdata_nxt = 32'hFFFF_FFFF;
    end

    w_awaddr_nxt = r_awaddr;
    w_wdata_nxt  = r_wdata;
    w_wstrb_nxt  = r_wstrb;
    w_araddr_nxt = r_araddr;
    w_arprot_nxt = r_arprot;
    if (w_acc && cmd_write) begin
      w_awaddr_nxt = {cmd_addr[31:2], 2'b00};
      w_wdata_nxt  = cmd_wdata;
      w_wstrb_nxt  = cmd_wstrb;
    end
    if (w_acc && !cmd_write) begin
      w_araddr_nxt = {cmd_addr[31:2], 2'b00};
      w_arprot_nxt = {cmd_insn, 2'b00};
    end

    w_cnt_nxt = '0;
    if ((w_state_nxt == r_state) &&
        (r_state == S_WRESP || r_state == S_RDATA)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign busy            = r_busy;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_timeout     = r_rsp_timeout;
  assign rsp_rdata       = r_rsp_rdata;
  assign mem_axi_awvalid = r_awvalid;
  assign mem_axi_awaddr  = r_awaddr;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = r_wvalid;
  assign mem_axi_wdata   = r_wdata;
  assign mem_axi_wstrb   = r_wstrb;
  assign mem_axi_bready  = r_bready;
  assign mem_axi_arvalid = r_arvalid;
  assign mem_axi_araddr  = r_araddr;
  assign mem_axi_arprot  = r_arprot;
  assign mem_axi_rready  = r_rready;

endmodule

// File: tb/tb_cw305_axi_initiator.sv
// tb_cw305_axi_initiator: randomized bench for cw305_axi_initiator with a
// behavioural responder and a cycle-count reference model.
`timescale 1ns/1ps
module tb_cw305_axi_initiator;

  localparam int TC1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        sel;
  logic        cmd_valid, cmd_write, cmd_insn;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] rdata;

  logic [1:0]  v_cmd_ready, v_rsp_valid, v_rsp_to, v_busy;
  logic [1:0]  v_awvalid, v_wvalid, v_bready, v_arvalid, v_rready;
  logic [31:0] v_rsp_rdata [2];
  logic [31:0] v_awaddr [2];
  logic [31:0] v_wdata [2];
  logic [31:0] v_araddr [2];
  logic [3:0]  v_wstrb [2];
  logic [2:0]  v_awprot [2];
  logic [2:0]  v_arprot [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cw305_axi_initiator #(
      .TIMEOUT_CYCLES((g == 0) ? 255 : TC1),
      .TIMEOUT_W(8)
    ) dut (
      .clk(clk),
      .resetn(resetn),
      .cmd_valid((g == 0) ? (cmd_valid & ~sel) : (cmd_valid & sel)),
      .cmd_ready(v_cmd_ready[g]),
      .cmd_write(cmd_write),
      .cmd_insn(cmd_insn),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .cmd_wstrb(cmd_wstrb),
      .rsp_valid(v_rsp_valid[g]),
      .rsp_rdata(v_rsp_rdata[g]),
      .rsp_timeout(v_rsp_to[g]),
      .busy(v_busy[g]),
      .mem_axi_awvalid(v_awvalid[g]),
      .mem_axi_awready(awready),
      .mem_axi_awaddr(v_awaddr[g]),
      .mem_axi_awprot(v_awprot[g]),
      .mem_axi_wvalid(v_wvalid[g]),
      .mem_axi_wready(wready),
      .mem_axi_wdata(v_wdata[g]),
      .mem_axi_wstrb(v_wstrb[g]),
      .mem_axi_bvalid(bvalid),
      .mem_axi_bready(v_bready[g]),
      .mem_axi_arvalid(v_arvalid[g]),
      .mem_axi_arready(arready),
      .mem_axi_araddr(v_araddr[g]),
      .mem_axi_arprot(v_arprot[g]),
      .mem_axi_rvalid(rvalid),
      .mem_axi_rready(v_rready[g]),
      .mem_axi_rdata(rdata)
    );
  end

  logic o_cmd_ready, o_rsp_valid, o_rsp_to, o_busy;
  logic o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic [31:0] o_rsp_rdata, o_awaddr, o_wdata, o_araddr;
  logic [3:0] o_wstrb;
  logic [2:0] o_awprot, o_arprot;
  assign o_cmd_ready = v_cmd_ready[sel];
  assign o_rsp_valid = v_rsp_valid[sel];
  assign o_rsp_to    = v_rsp_to[sel];
  assign o_busy      = v_busy[sel];
  assign o_awvalid   = v_awvalid[sel];
  assign o_wvalid    = v_wvalid[sel];
  assign o_bready    = v_bready[sel];
  assign o_arvalid   = v_arvalid[sel];
  assign o_rready    = v_rready[sel];
  assign o_rsp_rdata = v_rsp_rdata[sel];
  assign o_awaddr    = v_awaddr[sel];
  assign o_wdata     = v_wdata[sel];
  assign o_araddr    = v_araddr[sel];
  assign o_wstrb     = v_wstrb[sel];
  assign o_awprot    = v_awprot[sel];
  assign o_arprot    = v_arprot[sel];

  typedef struct {
    int rsp_cyc; int n_rsp; int n_aw; int n_w; int n_b; int n_ar; int n_r;
    int first_v; int unstable; int proto;
    logic to; logic [31:0] rdata; logic [31:0] awaddr; logic [31:0] wdata;
    logic [31:0] araddr; logic [3:0] wstrb; logic [2:0] awprot; logic [2:0] arprot;
  } obs_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] bus_mem [8];
  logic [31:0] ref_mem [8];

  task automatic idle_inputs();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    rdata = $urandom; cmd_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 0; idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1;
    repeat (2) @(negedge clk);
  endtask

  // Drives one command and plays the responder; a/w are address/data
  // channel ready delays, d is the B/R valid delay after ready rises.
  task automatic run_txn(input bit wr, input bit insn, input logic [31:0] addr,
      input logic [31:0] wd, input logic [3:0] st, input int a, input int w,
      input int d, input bit hold_cmd, output obs_t o);
    logic [31:0] c_aw, c_wd, c_ar;
    logic [3:0] c_st;
    o = '{default: 0};
    o.rsp_cyc = -1;
    c_aw = 0; c_wd = 0; c_ar = 0; c_st = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_insn = insn;
    cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    if (!o_cmd_ready) o.proto++;
    @(posedge clk); #1;
    cmd_valid = hold_cmd; cmd_write = 1'($urandom); cmd_insn = 1'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (o_busy === o_cmd_ready) o.proto++;
      if (o_awvalid) begin
        if (o.n_aw == 0) begin
          o.first_v = c; o.awaddr = o_awaddr; o.awprot = o_awprot;
        end else if (o_awaddr !== o.awaddr || o_awprot !== o.awprot) o.unstable++;
        awready = (o.n_aw >= a); o.n_aw++;
        if (awready) c_aw = o_awaddr;
      end else awready = 0;
      if (o_wvalid) begin
        if (o.n_w == 0) begin
          o.wdata = o_wdata; o.wstrb = o_wstrb;
        end else if (o_wdata !== o.wdata || o_wstrb !== o.wstrb) o.unstable++;
        wready = (o.n_w >= w); o.n_w++;
        if (wready) begin c_wd = o_wdata; c_st = o_wstrb; end
      end else wready = 0;
      if (o_bready) begin
        if (o_awvalid || o_wvalid) o.proto++;
        bvalid = (o.n_b >= d); o.n_b++;
        if (bvalid)
          for (int k = 0; k < 4; k++)
            if (c_st[k]) bus_mem[c_aw[4:2]][8*k +: 8] = c_wd[8*k +: 8];
      end else bvalid = 0;
      if (o_arvalid) begin
        if (o.n_ar == 0) begin
          o.first_v = c; o.araddr = o_araddr; o.arprot = o_arprot;
        end else if (o_araddr !== o.araddr || o_arprot !== o.arprot) o.unstable++;
        arready = (o.n_ar >= a); o.n_ar++;
        if (arready) c_ar = o_araddr;
      end else arready = 0;
      if (o_rready) begin
        if (o_arvalid) o.proto++;
        rvalid = (o.n_r >= d); o.n_r++;
        rdata = rvalid ? bus_mem[c_ar[4:2]] : $urandom;
      end else begin
        rvalid = 0; rdata = $urandom;
      end
      if (o_rsp_valid) begin
        o.n_rsp++;
        if (!o_cmd_ready) o.proto++;
        if (o.rsp_cyc < 0) begin
          o.rsp_cyc = c; o.to = o_rsp_to; o.rdata = o_rsp_rdata;
          cmd_valid = 0;
        end
      end
      if (o.rsp_cyc > 0 && c >= o.rsp_cyc + 2) break;
    end
    idle_inputs();
  endtask

  function automatic obs_t model(input bit wr, input bit insn,
      input logic [31:0] addr, input int a, input int w, input int d,
      input int tc);
    obs_t e;
    bit t;
    e = '{default: 0};
    e.n_rsp = 1; e.first_v = 1;
    t = (tc != 0) && (d >= tc);
    e.to = t;
    if (wr) begin
      e.n_aw = a + 1; e.n_w = w + 1; e.n_b = t ? tc : d + 1;
      e.rsp_cyc = ((a > w) ? a : w) + 1 + e.n_b + 1;
      e.awaddr = addr & ~32'h3;
      e.rdata = 32'hFFFF_FFFF;
    end else begin
      e.n_ar = a + 1; e.n_r = t ? tc : d + 1;
      e.rsp_cyc = e.n_ar + e.n_r + 1;
      e.araddr = addr & ~32'h3;
      e.arprot = {insn, 2'b00};
      e.rdata = t ? 32'hFFFF_FFFF : ref_mem[addr[4:2]];
    end
    return e;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wd,
      input logic [3:0] st);
    for (int k = 0; k < 4; k++)
      if (st[k]) ref_mem[addr[4:2]][8*k +: 8] = wd[8*k +: 8];
  endtask

  task automatic test_reset();
    sel = 0; idle_inputs(); resetn = 1;
    #3 resetn = 0;
    #2;
    checks++;
    if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
         o_rsp_valid, o_rsp_to, o_cmd_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000", {o_awvalid, o_wvalid,
        o_bready, o_arvalid, o_rready, o_rsp_valid, o_rsp_to, o_cmd_ready});
    end
    checks++;
    if ({o_awaddr, o_wdata, o_wstrb, o_araddr, o_arprot, o_awprot,
         o_rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_data nonzero rsp_rdata=%h awaddr=%h",
        o_rsp_rdata, o_awaddr);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy got %b want 1", o_busy);
    end
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
    checks++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_release cmd_ready=%b busy=%b want 1/0",
        o_cmd_ready, o_busy);
    end
  endtask

  task automatic test_write_basic();
    obs_t o, e;
    e = model(1, 0, 32'h7, 0, 0, 0, 255);
    run_txn(1, 0, 32'h7, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, o);
    ref_write(32'h7, 32'hDEADBEEF, 4'hF);
    checks++; if (o.awaddr !== 32'h4) begin errors++;
      $display("FAIL wr_awaddr got %h want 00000004", o.awaddr); end
    checks++; if (o.n_aw !== 1 || o.n_w !== 1) begin errors++;
      $display("FAIL wr_valid_len aw=%0d w=%0d want 1/1", o.n_aw, o.n_w); end
    checks++; if (o.first_v !== 1) begin errors++;
      $display("FAIL wr_first_valid got %0d want 1", o.first_v); end
    checks++; if (o.rsp_cyc !== e.rsp_cyc) begin errors++;
      $display("FAIL wr_latency got %0d want %0d", o.rsp_cyc, e.rsp_cyc); end
    checks++; if (o.to !== 1'b0 || o.n_rsp !== 1) begin errors++;
      $display("FAIL wr_rsp to=%b n=%0d want 0/1", o.to, o.n_rsp); end
    checks++; if (o.wdata !== 32'hDEADBEEF || o.wstrb !== 4'hF) begin errors++;
      $display("FAIL wr_payload got %h/%h want deadbeef/f", o.wdata, o.wstrb); end
    checks++; if (o.awprot !== 3'b000 || o.proto !== 0) begin errors++;
      $display("FAIL wr_proto awprot=%b proto=%0d want 000/0", o.awprot, o.proto); end
  endtask

  task automatic test_skewed_write();
    obs_t o, e;
    int d;
    logic [31:0] wd;
    d = $urandom_range(0, 2); wd = $urandom;
    e = model(1, 0, 32'h18, 3, 0, d, 255);
    run_txn(1, 0, 32'h18, wd, 4'hF, 3, 0, d, 0, o);
    ref_write(32'h18, wd, 4'hF);
    checks++; if (o.n_w !== 1 || o.n_aw !== 4) begin errors++;
      $display("FAIL skew_valid_len aw=%0d w=%0d want 4/1", o.n_aw, o.n_w); end
    checks++; if (o.unstable !== 0) begin errors++;
      $display("FAIL skew_stable got %0d want 0", o.unstable); end
    checks++; if (o.proto !== 0 || o.n_b !== e.n_b) begin errors++;
      $display("FAIL skew_bready proto=%0d nb=%0d want 0/%0d", o.proto, o.n_b, e.n_b); end
    checks++; if (o.n_rsp !== 1 || o.rsp_cyc !== e.rsp_cyc) begin errors++;
      $display("FAIL skew_rsp n=%0d cyc=%0d want 1/%0d", o.n_rsp, o.rsp_cyc, e.rsp_cyc); end
  endtask

  task automatic test_read_insn();
    obs_t o, e;
    logic [31:0] addr;
    addr = {$urandom_range(0, 255), 3'b010, 5'b0_1101};
    bus_mem[addr[4:2]] = 32'h12345678; ref_mem[addr[4:2]] = 32'h12345678;
    e = model(0, 1, addr, 0, 0, 5, 255);
    run_txn(0, 1, addr, 0, 0, 0, 0, 5, 0, o);
    checks++; if (o.arprot !== 3'b100 || o.araddr !== e.araddr) begin errors++;
      $display("FAIL rd_ar got %b/%h want 100/%h", o.arprot, o.araddr, e.araddr); end
    checks++; if (o.n_r !== 6) begin errors++;
      $display("FAIL rd_rready_len got %0d want 6", o.n_r); end
    checks++; if (o.rdata !== 32'h12345678 || o.to !== 1'b0) begin errors++;
      $display("FAIL rd_data got %h/%b want 12345678/0", o.rdata, o.to); end
    checks++; if (o.n_rsp !== 1 || o.rsp_cyc !== e.rsp_cyc) begin errors++;
      $display("FAIL rd_rsp n=%0d cyc=%0d want 1/%0d", o.n_rsp, o.rsp_cyc, e.rsp_cyc); end
  endtask

  task automatic test_random();
    obs_t o, e;
    for (int i = 0; i < 40; i++) begin
      bit wr, insn, hold;
      logic [31:0] addr, wd;
      logic [3:0] st;
      int a, w, d;
      wr = 1'($urandom); insn = 1'($urandom); hold = 1'($urandom);
      addr = $urandom; wd = $urandom; st = 4'($urandom);
      a = $urandom_range(0, 4); w = $urandom_range(0, 4); d = $urandom_range(0, 6);
      e = model(wr, insn, addr, a, w, d, 255);
      run_txn(wr, insn, addr, wd, st, a, w, d, hold, o);
      if (wr) ref_write(addr, wd, st);
      checks++; if (o.rsp_cyc !== e.rsp_cyc || o.n_rsp !== 1) begin errors++;
        $display("FAIL rnd%0d rsp cyc=%0d n=%0d want %0d/1", i, o.rsp_cyc, o.n_rsp, e.rsp_cyc); end
      checks++; if (o.to !== 1'b0 || o.proto !== 0 || o.unstable !== 0) begin errors++;
        $display("FAIL rnd%0d flags to=%b proto=%0d unst=%0d want 0", i, o.to, o.proto, o.unstable); end
      checks++; if (o.first_v !== 1) begin errors++;
        $display("FAIL rnd%0d first_valid got %0d want 1", i, o.first_v); end
      if (wr) begin
        checks++; if (o.n_aw !== e.n_aw || o.n_w !== e.n_w || o.n_b !== e.n_b) begin errors++;
          $display("FAIL rnd%0d wlens %0d/%0d/%0d want %0d/%0d/%0d", i,
            o.n_aw, o.n_w, o.n_b, e.n_aw, e.n_w, e.n_b); end
        checks++; if (o.awaddr !== e.awaddr || o.wdata !== wd || o.wstrb !== st) begin errors++;
          $display("FAIL rnd%0d wpay %h/%h/%h want %h/%h/%h", i,
            o.awaddr, o.wdata, o.wstrb, e.awaddr, wd, st); end
      end else begin
        checks++; if (o.n_ar !== e.n_ar || o.n_r !== e.n_r) begin errors++;
          $display("FAIL rnd%0d rlens %0d/%0d want %0d/%0d", i, o.n_ar, o.n_r, e.n_ar, e.n_r); end
        checks++; if (o.araddr !== e.araddr || o.arprot !== e.arprot) begin errors++;
          $display("FAIL rnd%0d ar %h/%b want %h/%b", i, o.araddr, o.arprot, e.araddr, e.arprot); end
        checks++; if (o.rdata !== e.rdata) begin errors++;
          $display("FAIL rnd%0d rdata got %h want %h", i, o.rdata, e.rdata); end
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    int a;
    @(negedge clk); sel = 1;
    repeat (2) @(negedge clk);
    a = $urandom_range(0, 2);
    e = model(0, 0, 32'h8, a, 0, 1000, TC1);
    run_txn(0, 0, 32'h8, 0, 0, a, 0, 1000, 0, o);
    checks++; if (o.to !== 1'b1 || o.rdata !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL to_rd_rsp got %b/%h want 1/ffffffff", o.to, o.rdata); end
    checks++; if (o.rsp_cyc !== e.rsp_cyc || o.n_r !== TC1) begin errors++;
      $display("FAIL to_rd_time cyc=%0d nr=%0d want %0d/%0d", o.rsp_cyc, o.n_r, e.rsp_cyc, TC1); end
    checks++; if (o.proto !== 0 || o.n_rsp !== 1 || o_rready !== 1'b0) begin errors++;
      $display("FAIL to_rd_after proto=%0d n=%0d rready=%b", o.proto, o.n_rsp, o_rready); end
    do_reset();
    e = model(1, 0, 32'h10, a, 1, 1000, TC1);
    run_txn(1, 0, 32'h10, 32'hCAFE0001, 4'hF, a, 1, 1000, 0, o);
    checks++; if (o.to !== 1'b1 || o.rdata !== 32'hFFFF_FFFF || o.n_b !== TC1) begin errors++;
      $display("FAIL to_wr_rsp got %b/%h nb=%0d want 1/ffffffff/%0d", o.to, o.rdata, o.n_b, TC1); end
    checks++; if (o.rsp_cyc !== e.rsp_cyc || o.proto !== 0) begin errors++;
      $display("FAIL to_wr_time cyc=%0d proto=%0d want %0d/0", o.rsp_cyc, o.proto, e.rsp_cyc); end
    do_reset();
  endtask

  task automatic test_timeout_boundary();
    obs_t o, e;
    logic [31:0] addr;
    addr = 32'h0000_0014;
    bus_mem[addr[4:2]] = 32'hA5C3_0F96; ref_mem[addr[4:2]] = 32'hA5C3_0F96;
    e = model(0, 0, addr, 0, 0, TC1 - 1, TC1);
    run_txn(0, 0, addr, 0, 0, 0, 0, TC1 - 1, 0, o);
    checks++; if (o.to !== 1'b0 || o.rdata !== 32'hA5C3_0F96) begin errors++;
      $display("FAIL bnd_rsp got %b/%h want 0/a5c30f96", o.to, o.rdata); end
    checks++; if (o.rsp_cyc !== e.rsp_cyc || o.n_r !== TC1 || o.n_rsp !== 1) begin errors++;
      $display("FAIL bnd_time cyc=%0d nr=%0d n=%0d want %0d/%0d/1",
        o.rsp_cyc, o.n_r, o.n_rsp, e.rsp_cyc, TC1); end
    @(negedge clk); sel = 0;
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    int seen;
    seen = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_insn = 0;
    cmd_addr = 32'h104; cmd_wdata = 32'h55AA_55AA; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 0; wready = 1; awready = 0;
    @(negedge clk); wready = 0;
    @(negedge clk);
    checks++; if (o_awvalid !== 1'b1) begin errors++;
      $display("FAIL mid_pre awvalid got %b want 1", o_awvalid); end
    #2 resetn = 0;
    #1;
    checks++; if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL mid_async got %b want 000000",
        {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid}); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) resetn = 1;
      if (o_rsp_valid) seen++;
    end
    checks++; if (seen !== 0 || o_cmd_ready !== 1'b1) begin errors++;
      $display("FAIL mid_norsp rsp=%0d cmd_ready=%b want 0/1", seen, o_cmd_ready); end
    e = model(1, 0, 32'h104, 1, 2, 1, 255);
    run_txn(1, 0, 32'h104, 32'h0BAD_F00D, 4'h3, 1, 2, 1, 0, o);
    ref_write(32'h104, 32'h0BAD_F00D, 4'h3);
    checks++; if (o.rsp_cyc !== e.rsp_cyc || o.to !== 1'b0 || o.n_rsp !== 1) begin errors++;
      $display("FAIL mid_after cyc=%0d to=%b n=%0d want %0d/0/1",
        o.rsp_cyc, o.to, o.n_rsp, e.rsp_cyc); end
    checks++; if (o.awaddr !== 32'h104 || o.proto !== 0) begin errors++;
      $display("FAIL mid_after_addr got %h proto=%0d want 00000104/0", o.awaddr, o.proto); end
  endtask

  task automatic test_readback();
    obs_t o;
    for (int i = 0; i < 8; i++) begin
      run_txn(0, 0, 32'(i * 4), 0, 0, 0, 0, $urandom_range(0, 2), 0, o);
      checks++; if (o.rdata !== ref_mem[i]) begin errors++;
        $display("FAIL readback%0d got %h want %h", i, o.rdata, ref_mem[i]); end
    end
  endtask

  initial begin
    cmd_write = 0; cmd_insn = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus_mem[i] = $urandom; ref_mem[i] = bus_mem[i];
    end
    test_reset();
    test_write_basic();
    test_skewed_write();
    test_read_insn();
    test_random();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cw305_axi_initiator.md
Name: cw305_axi_initiator

Overview:
AXI4-Lite master that turns single-word commands from the CW305 host register interface into transactions on the picorv32-side mem_axi bus. The existing mem_axi port set is driven from the initiator end, so the host can load plaintext/key words into shared memory and read back ciphertext words. The block runs one outstanding transaction at a time. A response-phase timeout stops the host from hanging on a dead responder.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in a response-wait state before abort; 0 disables the timeout.
TIMEOUT_W, 8, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  single clock, all logic on posedge
resetn  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command request
cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_insn  in  1  drives arprot[2] on reads
cmd_addr  in  32  byte address; bits [1:0] forced to 0 on the bus
cmd_wdata  in  32  write data
cmd_wstrb  in  4  write byte strobes
rsp_valid  out  1  one-cycle pulse, command finished
rsp_rdata  out  32  read data, held until next rsp_valid
rsp_timeout  out  1  qualifies rsp_valid: 1 = aborted by timeout
busy  out  1  equals !cmd_ready
mem_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  out/in/out/out  AW channel
mem_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  out/in/out/out  W channel
mem_axi_bvalid/bready  in/out  B channel
mem_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  out/in/out/out  AR channel
mem_axi_rvalid/rready/rdata[31:0]  in/out/in  R channel

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE. All valid and ready outputs 0. rsp_valid=0, rsp_timeout=0, rsp_rdata=0, bus address/data/strb/prot=0, cmd_ready=1 after release.
- All outputs are registered. The FSM has states IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE: cmd_ready=1. On accept, latch addr&~3, wdata, wstrb, insn. Next state is WADDR if cmd_write, else RADDR.
- WADDR: awvalid and wvalid both rise in the first cycle after accept.
  - Each channel deasserts independently on the posedge where its valid&&ready=1.
  - Handshakes may complete in the same cycle or in either order.
  - When both are done, go to WRESP. awprot=3'b000.
- WRESP: bready=1. On bvalid&&bready: rsp_valid=1 with rsp_timeout=0 the next cycle, bready drops, go to IDLE.
- RADDR: arvalid=1, arprot={insn,2'b00}. On handshake, go to RDATA.
- RDATA: rready=1. On rvalid&&rready: latch rdata into rsp_rdata, rsp_valid=1, go to IDLE.
- Minimum latency with always-ready responder: accept at edge E. Valids high in cycle E+1. bready/rready high in cycle E+2. rsp_valid and cmd_ready high in cycle E+3.
- Valid stability: once asserted, a valid and its payload are held unchanged until its handshake. Address-phase states never time out, per AXI rules.
- Timeout: the counter clears on entry to WRESP/RDATA and increments each cycle there.
  - If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES with no response: drop the ready, pulse rsp_valid with rsp_timeout=1, set rsp_rdata=32'hFFFFFFFF, go to IDLE.
  - If the response arrives in the same cycle the count hits the limit, the response wins (rsp_timeout=0).
- A response arriving after a timeout is not consumed. It may be attributed to the next transaction. Host software must pulse resetn after any timeout.
- cmd_valid while busy is ignored; nothing is queued. cmd_* inputs are sampled only at accept.
- rsp_valid is exactly one cycle and never coincides with cmd_ready=0.
- Reset mid-transaction aborts immediately. No rsp_valid is produced for the aborted command.

Test Plan:
1. Write with always-ready responder: addr 0x0000_0007, data 0xDEADBEEF, strb 4'hF -> awaddr=0x0000_0004, awvalid and wvalid high exactly 1 cycle, rsp_valid at E+3, rsp_timeout=0.
2. Skewed write: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, bready only after both handshakes, a single rsp_valid.
3. Read with insn=1 and rvalid delayed 5 cycles, rdata 0x12345678 -> arprot=3'b100, rready held 6 cycles, rsp_rdata=0x12345678, rsp_valid for 1 cycle.
4. TIMEOUT_CYCLES=4, responder never asserts rvalid -> rsp_valid with rsp_timeout=1 and rsp_rdata=0xFFFFFFFF exactly 4 cycles after RDATA entry, rready=0, cmd_ready=1.
5. Boundary: rvalid arrives on the 4th RDATA cycle with TIMEOUT_CYCLES=4 -> normal response, rsp_timeout=0.
6. resetn low while awvalid=1 and awready=0 -> awvalid=0 immediately (asynchronous), no rsp_valid; after release, a new write completes normally.
